display_file_fetcher: RTL

//  Parametrised display-file fetch unit for one video plane. Issues burst reads from VSR into a

---
 rtl/display_file_fetcher.sv | 218 +++++++++++++++++++++
 1 files changed

// File: rtl/display_file_fetcher.sv
`default_nettype none
// ==========================================================================================
// display_file_fetcher : burst-reads one video plane's display file into a word FIFO and
//                        serialises the words into 16/8/4 bpp pixels.       Rev 1.0
// ==========================================================================================
module display_file_fetcher #(
   parameter int ADDR_W      = 22,
   parameter int FIFO_DEPTH  = 8,
   parameter int BURST_WORDS = 4
) (
   input  logic              clk,
   input  logic              reset,
   output logic [ADDR_W-1:0] address,
   output logic              as,
   input  logic [15:0]       din,
   input  logic              bus_ack,
   input  logic              burstdata_valid,
   input  logic              reload_vsr,
   input  logic [ADDR_W-1:0] vsr_in,
   input  logic [1:0]        mode_in,
   input  logic              read_pixels,
   output logic              pix_valid,
   input  logic              pix_strobe,
   output logic [15:0]       pix_data,
   output logic              underflow
);

   localparam int c_cnt_w = $clog2(FIFO_DEPTH) + 1;
   localparam int c_ptr_w = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam logic [c_cnt_w-1:0] c_depth   = c_cnt_w'(FIFO_DEPTH);
   localparam logic [c_cnt_w-1:0] c_burst   = c_cnt_w'(BURST_WORDS);
   localparam logic [c_cnt_w-1:0] c_cnt_one = c_cnt_w'(1);
   localparam logic [c_ptr_w-1:0] c_ptr_one = c_ptr_w'(1);
   localparam logic [ADDR_W-1:0]  c_two     = ADDR_W'(2);
   localparam logic [ADDR_W-1:0]  c_bmask   = ADDR_W'(BURST_WORDS - 1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_READ  = 2'd1,
      ST_DRAIN = 2'd2
   } state_t;

   state_t              state_q, state_d;
   logic                as_q, as_d;
   logic                discard_q, discard_d;
   logic [ADDR_W-1:0]   vsr_q, vsr_d;
   logic [1:0]          mode_q, mode_d;
   logic [c_ptr_w-1:0]  wr_ptr_q, wr_ptr_d;
   logic [c_ptr_w-1:0]  rd_ptr_q, rd_ptr_d;
   logic [c_cnt_w-1:0]  count_q, count_d;
   logic [1:0]          sub_q, sub_d;
   logic [15:0]         rd_data_q, rd_data_d;
   logic                hazard_q, hazard_d;
   logic                underflow_q, underflow_d;
   logic [15:0]         mem_q [FIFO_DEPTH];

   logic                push_w;
   logic                pop_w;
   logic                take_w;
   logic                pix_valid_w;
   logic [1:0]          last_sub_w;
   logic [ADDR_W-1:0]   vsr_inc_w;
   logic [15:0]         pix_data_w;

   // A word written this cycle into the slot being read is not visible in rd_data yet.
   assign pix_valid_w = (count_q != '0) && !hazard_q;

   always_comb begin
      state_d     = state_q;
      as_d        = as_q;
      discard_d   = discard_q;
      vsr_d       = vsr_q;
      mode_d      = mode_q;
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      count_d     = count_q;
      sub_d       = sub_q;
      underflow_d = underflow_q;
      push_w      = 1'b0;
      pop_w       = 1'b0;
      vsr_inc_w   = vsr_q + c_two;

      unique case (mode_q)
         2'd1:    last_sub_w = 2'd3;
         2'd2:    last_sub_w = 2'd0;
         default: last_sub_w = 2'd1;
      endcase
      take_w = pix_strobe && pix_valid_w;

      if (reload_vsr) begin
         vsr_d       = vsr_in;
         mode_d      = mode_in;
         wr_ptr_d    = '0;
         rd_ptr_d    = '0;
         count_d     = '0;
         sub_d       = 2'd0;
         underflow_d = 1'b0;
         discard_d   = 1'b0;
         // An outstanding bus request must still be closed by the arbiter.
         if ((state_q != ST_IDLE) && !bus_ack) begin
            state_d = ST_DRAIN;
            as_d    = 1'b1;
         end else begin
            state_d = ST_IDLE;
            as_d    = 1'b0;
         end
      end else begin
         if (pix_strobe && !pix_valid_w) underflow_d = 1'b1;
         if (take_w) begin
            pop_w = (sub_q == last_sub_w);
            sub_d = pop_w ? 2'd0 : sub_q + 2'd1;
         end

         unique case (state_q)
            ST_IDLE: begin
               if (read_pixels && ((c_depth - count_q) >= c_burst)) begin
                  state_d = ST_READ;
                  as_d    = 1'b1;
               end
            end
            ST_READ: begin
               if (burstdata_valid && !discard_q) begin
                  push_w = 1'b1;
                  vsr_d  = vsr_inc_w;
                  // Crossing the aligned block means the rest of the burst has wrapped.
                  if (((vsr_inc_w >> 1) & c_bmask) == '0) discard_d = 1'b1;
               end
               if (bus_ack) begin
                  as_d      = 1'b0;
                  discard_d = 1'b0;
                  state_d   = ST_IDLE;
               end
            end
            ST_DRAIN: begin
               if (bus_ack) begin
                  as_d    = 1'b0;
                  state_d = ST_IDLE;
               end
            end
            default: begin
               as_d    = 1'b0;
               state_d = ST_IDLE;
            end
         endcase

         if (push_w) wr_ptr_d = wr_ptr_q + c_ptr_one;
         if (pop_w)  rd_ptr_d = rd_ptr_q + c_ptr_one;
         unique case ({push_w, pop_w})
            2'b10:   count_d = count_q + c_cnt_one;
            2'b01:   count_d = count_q - c_cnt_one;
            default: count_d = count_q;
         endcase
      end

      hazard_d  = push_w && (wr_ptr_q == rd_ptr_d);
      rd_data_d = mem_q[rd_ptr_d];
   end

   always_comb begin
      pix_data_w = 16'h0000;
      unique case (mode_q)
         2'd2: pix_data_w = rd_data_q;
         2'd1: begin
            unique case (sub_q)
               2'd0:    pix_data_w = {12'h000, rd_data_q[15:12]};
               2'd1:    pix_data_w = {12'h000, rd_data_q[11:8]};
               2'd2:    pix_data_w = {12'h000, rd_data_q[7:4]};
               default: pix_data_w = {12'h000, rd_data_q[3:0]};
            endcase
         end
         default: pix_data_w = sub_q[0] ? {8'h00, rd_data_q[7:0]} : {8'h00, rd_data_q[15:8]};
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= ST_IDLE;
         as_q        <= 1'b0;
         discard_q   <= 1'b0;
         vsr_q       <= '0;
         mode_q      <= 2'd0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         sub_q       <= 2'd0;
         rd_data_q   <= 16'h0000;
         hazard_q    <= 1'b0;
         underflow_q <= 1'b0;
         for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= 16'h0000;
      end else begin
         state_q     <= state_d;
         as_q        <= as_d;
         discard_q   <= discard_d;
         vsr_q       <= vsr_d;
         mode_q      <= mode_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         sub_q       <= sub_d;
         rd_data_q   <= rd_data_d;
         hazard_q    <= hazard_d;
         underflow_q <= underflow_d;
         if (push_w) mem_q[wr_ptr_q] <= din;
      end
   end

   always @(posedge clk) begin
      if (reset && push_w) assert (count_q != c_depth);
   end

   assign address   = vsr_q;
   assign as        = as_q;
   assign pix_valid = pix_valid_w;
   assign pix_data  = pix_data_w;
   assign underflow = underflow_q;

endmodule
`default_nettype wire
